// File: rtl/alu_2bit_unit.sv
// 2-bit registered ALU: eight operations on A/B, with Result, Carry and Zero
// registered one cycle after a valid operand/opcode sample.
module alu_2bit_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [2:0] ALU_Sel,
  output logic [1:0] Result,
  output logic       Carry,
  output logic       Zero,
  output logic       out_valid
);

  logic [2:0] op_out;

  // Bit 2 carries the carry/borrow/shifted-out bit; bits 1:0 the result.
  always_comb begin
    op_out = 3'b000;
    case (ALU_Sel)
      3'b000: op_out = {1'b0, A} + {1'b0, B};
      3'b001: op_out = {1'b0, A} - {1'b0, B};
      3'b010: op_out = {1'b0, A & B};
      3'b011: op_out = {1'b0, A | B};
      3'b100: op_out = {1'b0, A ^ B};
      3'b101: op_out = {1'b0, ~A};
      3'b110: op_out = {A[1], A[0], 1'b0};
      3'b111: op_out = {A[0], 1'b0, A[1]};
      default: op_out = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Result    <= 2'b00;
      Carry     <= 1'b0;
      Zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Result <= op_out[1:0];
        Carry  <= op_out[2];
        Zero   <= (op_out[1:0] == 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_alu_2bit_unit.sv
// Self-checking bench for alu_2bit_unit: directed cases plus random ops,
// compared against an arithmetic reference model.
module tb_alu_2bit_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] A = 2'b00;
  logic [1:0] B = 2'b00;
  logic [2:0] ALU_Sel = 3'b000;
  logic [1:0] Result;
  logic       Carry;
  logic       Zero;
  logic       out_valid;

  int checks = 0;
  int fails  = 0;

  logic [1:0] exp_res = 2'b00;
  logic       exp_c   = 1'b0;
  logic       exp_z   = 1'b1;
  logic       exp_v   = 1'b0;

  alu_2bit_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .Result(Result), .Carry(Carry), .Zero(Zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Reference computed from plain integer arithmetic on the operand values.
  task automatic ref_alu(input int a, input int b, input int sel,
                         output logic [1:0] res, output logic c);
    int r, cc;
    r = 0; cc = 0;
    case (sel)
      0: begin r = (a + b) % 4;     cc = ((a + b) >= 4) ? 1 : 0; end
      1: begin r = (a - b + 4) % 4; cc = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 3 - a;
      6: begin r = (a * 2) % 4; cc = a / 2; end
      default: begin r = a / 2; cc = a % 2; end
    endcase
    res = r[1:0];
    c   = cc[0];
  endtask

  task automatic check_all(input string tag);
    check({tag, "_res"},   {2'b00, Result},  {2'b00, exp_res});
    check({tag, "_carry"}, {3'b000, Carry},  {3'b000, exp_c});
    check({tag, "_zero"},  {3'b000, Zero},   {3'b000, exp_z});
    check({tag, "_valid"}, {3'b000, out_valid}, {3'b000, exp_v});
  endtask

  task automatic do_op(input string tag, input logic v, input logic [1:0] a,
                       input logic [1:0] b, input logic [2:0] sel);
    logic [1:0] r;
    logic       c;
    @(negedge clk);
    in_valid = v; A = a; B = b; ALU_Sel = sel;
    @(posedge clk);
    exp_v = v;
    if (v) begin
      ref_alu(int'(a), int'(b), int'(sel), r, c);
      exp_res = r; exp_c = c; exp_z = (r == 2'b00);
    end
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    exp_res = 2'b00; exp_c = 1'b0; exp_z = 1'b1; exp_v = 1'b0;
  endtask

  initial begin
    // 1: asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    do_op("rst_hold1", 1'b0, 2'b11, 2'b11, 3'b000);
    do_op("rst_hold2", 1'b0, 2'b10, 2'b01, 3'b001);

    // 2: A=01,B=01 back to back ADD..XOR
    do_op("add11", 1'b1, 2'b01, 2'b01, 3'b000);
    check("add11_lit", {out_valid, Carry, Result}, 4'b1010);
    do_op("sub11", 1'b1, 2'b01, 2'b01, 3'b001);
    check("sub11_lit", {Zero, Carry, Result}, 4'b1000);
    do_op("and11", 1'b1, 2'b01, 2'b01, 3'b010);
    check("and11_lit", {2'b00, Result}, 4'b0001);
    do_op("or11",  1'b1, 2'b01, 2'b01, 3'b011);
    check("or11_lit", {2'b00, Result}, 4'b0001);
    do_op("xor11", 1'b1, 2'b01, 2'b01, 3'b100);
    check("xor11_lit", {Zero, 1'b0, Result}, 4'b1000);

    // 3: carry and borrow
    do_op("add_ovf", 1'b1, 2'b11, 2'b11, 3'b000);
    check("add_ovf_lit", {Zero, Carry, Result}, 4'b0110);
    do_op("sub_brw", 1'b1, 2'b00, 2'b01, 3'b001);
    check("sub_brw_lit", {Zero, Carry, Result}, 4'b0111);

    // 4: NOT / shifts
    do_op("not", 1'b1, 2'b10, 2'b11, 3'b101);
    check("not_lit", {Zero, Carry, Result}, 4'b0001);
    do_op("shl", 1'b1, 2'b11, 2'b00, 3'b110);
    check("shl_lit", {Zero, Carry, Result}, 4'b0110);
    do_op("shr", 1'b1, 2'b01, 2'b10, 3'b111);
    check("shr_lit", {Zero, Carry, Result}, 4'b1100);

    // 5: idle cycles hold the last result
    do_op("hold1", 1'b0, 2'b10, 2'b10, 3'b000);
    check("hold1_lit", {Zero, Carry, Result}, 4'b1100);
    do_op("hold2", 1'b0, 2'b11, 2'b01, 3'b001);
    check("hold2_lit", {out_valid, Carry, Result}, 4'b0100);

    // 6: reset while an op is pending discards it
    do_op("pre_rst", 1'b1, 2'b10, 2'b01, 3'b011);
    @(negedge clk);
    in_valid = 1'b1; A = 2'b11; B = 2'b10; ALU_Sel = 3'b000;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_all("rst_pend");
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    do_op("post_rst_idle", 1'b0, 2'b11, 2'b10, 3'b000);
    do_op("post_rst_op", 1'b1, 2'b10, 2'b11, 3'b000);
    check("post_rst_lit", {out_valid, Carry, Result}, 4'b1101);

    // Random ops, mostly valid, against the reference model
    for (int i = 0; i < 300; i++) begin
      do_op("rand", ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
